// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce reporter: queues nonces from the miner in a small FIFO and
// sends each one to the host as four 8N1 UART bytes, least-significant byte first.
// Back-to-back nonces are sent with no idle bit between them. On the edge that
// ends the final stop bit, a waiting word is popped directly into START.
module golden_nonce_uart_tx #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic                     new_golden_ticket,
    input  logic [31:0]              golden_nonce,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nx;
    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_ovf;
    logic [31:0]   r_hold, w_hold_nx;
    logic [CW-1:0] r_baud, w_baud_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [1:0]    r_byte, w_byte_nx;
    logic          r_tx, w_tx_nx;

    logic          w_baud_done, w_last_stop, w_nonempty, w_full;
    logic          w_pop, w_push, w_drop;
    logic [31:0]   w_head;
    logic [7:0]    w_cur_byte;
    logic [2:0]    w_bit_inc;

    assign w_baud_done = (r_baud == CW'(CLKS_PER_BIT - 1));
    assign w_last_stop = (r_state == S_STOP) && w_baud_done && (r_byte == 2'd3);
    assign w_nonempty  = (r_count != '0);
    assign w_full      = (r_count == (PW+1)'(DEPTH));
    // A word leaves the FIFO either from IDLE or straight out of the last stop bit.
    assign w_pop       = w_nonempty && ((r_state == S_IDLE) || w_last_stop);
    assign w_push      = new_golden_ticket && (!w_full || w_pop);
    assign w_drop      = new_golden_ticket && w_full && !w_pop;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_cur_byte  = 8'(r_hold >> {r_byte, 3'b000});
    assign w_bit_inc   = r_bit + 3'd1;

    assign uart_tx    = r_tx;
    assign busy       = w_nonempty || (r_state != S_IDLE);
    assign overflow   = r_ovf;
    assign fifo_count = r_count;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge hash_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= golden_nonce;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: ;
            endcase
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // TX state register; uart_tx is registered so the line never glitches.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_hold  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_byte  <= w_byte_nx;
            r_hold  <= w_hold_nx;
            r_tx    <= w_tx_nx;
        end
    end

    // Next-state logic; the line value is computed for the state being entered.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud + CW'(1);
        w_bit_nx   = r_bit;
        w_byte_nx  = r_byte;
        w_hold_nx  = r_hold;
        w_tx_nx    = r_tx;
        case (r_state)
            S_IDLE: begin
                w_baud_nx = '0;
                w_tx_nx   = 1'b1;
                if (w_pop) begin
                    w_state_nx = S_START;
                    w_hold_nx  = w_head;
                    w_byte_nx  = 2'd0;
                    w_tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_nx = S_DATA;
                    w_baud_nx  = '0;
                    w_bit_nx   = 3'd0;
                    w_tx_nx    = w_cur_byte[0];
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nx = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_bit_nx = w_bit_inc;
                        w_tx_nx  = w_cur_byte[w_bit_inc];
                    end
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_nx = '0;
                    if (r_byte != 2'd3) begin
                        w_state_nx = S_START;
                        w_byte_nx  = r_byte + 2'd1;
                        w_tx_nx    = 1'b0;
                    end else if (w_pop) begin
                        w_state_nx = S_START;
                        w_hold_nx  = w_head;
                        w_byte_nx  = 2'd0;
                        w_tx_nx    = 1'b0;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_tx_nx    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

endmodule
